pool_window_feeder: RTL and testbench

- Producer end of the pooling stream interface. Walks a stored feature map in POOL x POOL windows, one element per cycle, and drives the window stream that the max-pool stage consumes: aa_en, aa_first_data, aa_last_data and packed data.
- Reads the map from a single-port buffer with 1-cycle read latency. All INPUT_NUM channels are packed per address.
- Sits between the conv output buffer and the max-pool stage.

---
 rtl/pool_window_feeder_if.sv | 30 +++
 rtl/pool_window_feeder.sv | 174 +++++++++++++++++
 tb/tb_pool_window_feeder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_feeder_if.sv
// Window-stream bundle between the conv output buffer, the window feeder and the max-pool stage.
// master = feeder side; slave = buffer/consumer/environment side.
interface pool_window_feeder_if #(
    parameter int INPUT_NUM = 6,
    parameter int WD        = 8,
    parameter int ADDR_W    = 10
);
    logic                           start;
    logic                           busy;
    logic                           done;
    logic                           mem_rd_en;
    logic [ADDR_W-1:0]              mem_rd_addr;
    logic [INPUT_NUM-1:0][WD-1:0]   mem_rd_data;
    logic                           aa_en;
    logic                           aa_first_data;
    logic                           aa_last_data;
    logic [INPUT_NUM-1:0][WD-1:0]   data_o;

    modport master (
        input  start, mem_rd_data,
        output busy, done, mem_rd_en, mem_rd_addr,
               aa_en, aa_first_data, aa_last_data, data_o
    );

    modport slave (
        output start, mem_rd_data,
        input  busy, done, mem_rd_en, mem_rd_addr,
               aa_en, aa_first_data, aa_last_data, data_o
    );
endinterface

// File: rtl/pool_window_feeder.sv
// Walks a stored feature map in POOL x POOL windows (dx innermost) and streams one element
// per cycle to the max-pool stage; data trails the flags by the buffer's 1-cycle read latency.
module pwf_lane #(
    parameter int WD = 8
) (
    input  logic          vld_i,
    input  logic [WD-1:0] din_i,
    output logic [WD-1:0] dout_o
);
    assign dout_o = vld_i ? din_i : '0;
endmodule

module pool_window_feeder #(
    parameter int INPUT_NUM = 6,
    parameter int IN_W      = 28,
    parameter int IN_H      = 28,
    parameter int POOL      = 2,
    parameter int ADDR_W    = 10,
    parameter int WD        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pool_window_feeder_if.master  bus
);
    localparam int OUT_W = IN_W / POOL;
    localparam int OUT_H = IN_H / POOL;
    localparam int OXW   = $clog2(OUT_W + 1);
    localparam int OYW   = $clog2(OUT_H + 1);

    localparam logic [1:0]        P_LAST    = 2'(POOL - 1);
    localparam logic [OXW-1:0]    OX_LAST   = OXW'(OUT_W - 1);
    localparam logic [OYW-1:0]    OY_LAST   = OYW'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] WIN_STEP  = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(POOL * IN_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e            state_q;
    logic [1:0]        dx_q, dx_d, dy_q, dy_d;
    logic [OXW-1:0]    ox_q, ox_d;
    logic [OYW-1:0]    oy_q, oy_d;
    // band = top-left of the current window row, win = top-left of the window,
    // row = start of the current line inside the window
    logic [ADDR_W-1:0] band_q, band_d, win_q, win_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_d;
    logic              first_d, last_d, last_elem;

    logic              busy_q, done_q, rd_en_q, first_q, last_q, rd_valid_q;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        dx_d   = dx_q;
        dy_d   = dy_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        band_d = band_q;
        win_d  = win_q;
        row_d  = row_q;
        last_elem = (dx_q == P_LAST) && (dy_q == P_LAST) &&
                    (ox_q == OX_LAST) && (oy_q == OY_LAST);
        if (dx_q != P_LAST) begin
            dx_d = dx_q + 2'd1;
        end else begin
            dx_d = '0;
            if (dy_q != P_LAST) begin
                dy_d  = dy_q + 2'd1;
                row_d = row_q + ROW_STEP;
            end else begin
                dy_d = '0;
                if (ox_q != OX_LAST) begin
                    ox_d  = ox_q + OXW'(1);
                    win_d = win_q + WIN_STEP;
                    row_d = win_d;
                end else begin
                    ox_d   = '0;
                    oy_d   = oy_q + OYW'(1);
                    band_d = band_q + BAND_STEP;
                    win_d  = band_d;
                    row_d  = band_d;
                end
            end
        end
        addr_d  = row_d + ADDR_W'(dx_d);
        first_d = (dx_d == 2'd0) && (dy_d == 2'd0);
        last_d  = (dx_d == P_LAST) && (dy_d == P_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dx_q       <= '0;
            dy_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            band_q     <= '0;
            win_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_q;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                        first_q <= 1'b1;
                        last_q  <= (POOL == 1);
                        dx_q    <= '0;
                        dy_q    <= '0;
                        ox_q    <= '0;
                        oy_q    <= '0;
                        band_q  <= '0;
                        win_q   <= '0;
                        row_q   <= '0;
                    end
                end
                RUN: begin
                    if (last_elem) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        dx_q    <= dx_d;
                        dy_q    <= dy_d;
                        ox_q    <= ox_d;
                        oy_q    <= oy_d;
                        band_q  <= band_d;
                        win_q   <= win_d;
                        row_q   <= row_d;
                        addr_q  <= addr_d;
                        first_q <= first_d;
                        last_q  <= last_d;
                    end
                end
                DRAIN: begin
                    // start is deliberately not looked at here
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.mem_rd_en     = rd_en_q;
    assign bus.mem_rd_addr   = addr_q;
    assign bus.aa_en         = rd_en_q;
    assign bus.aa_first_data = first_q;
    assign bus.aa_last_data  = last_q;

    for (genvar g = 0; g < INPUT_NUM; g++) begin : g_lane
        pwf_lane #(.WD(WD)) u_lane (
            .vld_i  (rd_valid_q),
            .din_i  (bus.mem_rd_data[g]),
            .dout_o (bus.data_o[g])
        );
    end
endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: three map geometries, a window-order model, a signed max-pool consumer.
module tb_pool_window_feeder;
    localparam int NCH = 6;
    localparam int WD  = 8;
    localparam int AW  = 10;

    typedef logic [NCH-1:0][WD-1:0] word_t;
    typedef struct packed {
        logic busy, done, en, aa_en, first, last;
        logic [AW-1:0] addr;
        word_t data;
    } obs_t;

    logic clk, rst;
    int   errors = 0, checks = 0;
    bit   chk_en = 0;
    int   t[3] = '{0, 0, 0};
    int   act_i = 0;
    int   seen[$];

    int lit1[$] = '{0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15};
    int lit2[$] = '{0,1,5,6,2,3,7,8,10,11,15,16,12,13,17,18};
    int lit3[$] = '{0,1,2,3,4,5,6,7,8};

    pool_window_feeder_if #(.INPUT_NUM(NCH), .WD(WD), .ADDR_W(AW)) if0 ();
    pool_window_feeder_if #(.INPUT_NUM(NCH), .WD(WD), .ADDR_W(AW)) if1 ();
    pool_window_feeder_if #(.INPUT_NUM(NCH), .WD(WD), .ADDR_W(AW)) if2 ();

    pool_window_feeder #(.INPUT_NUM(NCH), .IN_W(4), .IN_H(4), .POOL(2), .ADDR_W(AW), .WD(WD))
        u0 (.clk(clk), .rst(rst), .bus(if0.master));
    pool_window_feeder #(.INPUT_NUM(NCH), .IN_W(5), .IN_H(5), .POOL(2), .ADDR_W(AW), .WD(WD))
        u1 (.clk(clk), .rst(rst), .bus(if1.master));
    pool_window_feeder #(.INPUT_NUM(NCH), .IN_W(3), .IN_H(3), .POOL(1), .ADDR_W(AW), .WD(WD))
        u2 (.clk(clk), .rst(rst), .bus(if2.master));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int pw(int i); return (i == 0) ? 4 : (i == 1) ? 5 : 3; endfunction
    function automatic int pp(int i); return (i == 2) ? 1 : 2; endfunction
    function automatic int n_of(int i);
        return (pw(i) / pp(i)) * (pw(i) / pp(i)) * pp(i) * pp(i);
    endfunction

    // k-th read of a pass, from the window walk order
    function automatic int exp_addr(int i, int k);
        int p = pp(i), w = pw(i), ow = pw(i) / pp(i);
        int win = k / (p * p), e = k % (p * p);
        return ((win / ow) * p + e / p) * w + (win % ow) * p + e % p;
    endfunction

    function automatic word_t mem_word(int i, int a);
        word_t r;
        for (int c = 0; c < NCH; c++) r[c] = 8'((a * 37 + c * 91 + i * 11 + 200) % 256);
        return r;
    endfunction

    function automatic word_t pack_max(word_t a, word_t b);
        word_t r;
        for (int c = 0; c < NCH; c++) r[c] = ($signed(a[c]) > $signed(b[c])) ? a[c] : b[c];
        return r;
    endfunction

    function automatic word_t win_max(int i, int w);
        int p = pp(i);
        word_t r = mem_word(i, exp_addr(i, w * p * p));
        for (int e = 1; e < p * p; e++) r = pack_max(r, mem_word(i, exp_addr(i, w * p * p + e)));
        return r;
    endfunction

    function automatic obs_t model_obs(int i, int tt);
        obs_t o = '0;
        int n = n_of(i), p = pp(i);
        o.busy = (tt >= 1 && tt <= n + 1);
        o.done = (tt == n + 1);
        if (tt >= 1 && tt <= n) begin
            o.en = 1; o.aa_en = 1;
            o.addr  = AW'(exp_addr(i, tt - 1));
            o.first = ((tt - 1) % (p * p) == 0);
            o.last  = ((tt - 1) % (p * p) == p * p - 1);
        end
        if (tt >= 2 && tt <= n + 1) o.data = mem_word(i, exp_addr(i, tt - 2));
        return o;
    endfunction

    function automatic obs_t get_obs(int i);
        obs_t o = '0;
        case (i)
            0: begin o.busy = if0.busy; o.done = if0.done; o.en = if0.mem_rd_en; o.aa_en = if0.aa_en;
                     o.first = if0.aa_first_data; o.last = if0.aa_last_data;
                     o.addr = if0.mem_rd_addr; o.data = if0.data_o; end
            1: begin o.busy = if1.busy; o.done = if1.done; o.en = if1.mem_rd_en; o.aa_en = if1.aa_en;
                     o.first = if1.aa_first_data; o.last = if1.aa_last_data;
                     o.addr = if1.mem_rd_addr; o.data = if1.data_o; end
            default: begin o.busy = if2.busy; o.done = if2.done; o.en = if2.mem_rd_en; o.aa_en = if2.aa_en;
                     o.first = if2.aa_first_data; o.last = if2.aa_last_data;
                     o.addr = if2.mem_rd_addr; o.data = if2.data_o; end
        endcase
        return o;
    endfunction

    function automatic logic get_start(int i);
        return (i == 0) ? if0.start : (i == 1) ? if1.start : if2.start;
    endfunction

    task automatic set_start(int i, logic v);
        case (i)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_obs(string tag, obs_t a, obs_t e);
        chk({tag, " busy"},  64'(a.busy),  64'(e.busy));
        chk({tag, " done"},  64'(a.done),  64'(e.done));
        chk({tag, " rd_en"}, 64'(a.en),    64'(e.en));
        chk({tag, " aa_en"}, 64'(a.aa_en), 64'(e.aa_en));
        chk({tag, " first"}, 64'(a.first), 64'(e.first));
        chk({tag, " last"},  64'(a.last),  64'(e.last));
        chk({tag, " addr"},  64'(a.addr),  64'(e.addr));
        chk({tag, " data"},  64'(a.data),  64'(e.data));
    endtask

    // buffer models: 1-cycle read latency
    always @(posedge clk) if (if0.mem_rd_en) if0.mem_rd_data <= mem_word(0, int'(if0.mem_rd_addr));
    always @(posedge clk) if (if1.mem_rd_en) if1.mem_rd_data <= mem_word(1, int'(if1.mem_rd_addr));
    always @(posedge clk) if (if2.mem_rd_en) if2.mem_rd_data <= mem_word(2, int'(if2.mem_rd_addr));

    // pass position per instance: 0 idle, 1..N reads, N+1 drain
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst)                   t[i] <= 0;
            else if (t[i] == 0)        t[i] <= get_start(i) ? 1 : 0;
            else if (t[i] == n_of(i) + 1) t[i] <= 0;
            else                       t[i] <= t[i] + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            for (int i = 0; i < 3; i++) cmp_obs($sformatf("i%0d", i), get_obs(i), model_obs(i, t[i]));
    end

    always @(negedge clk) begin
        obs_t o;
        o = get_obs(act_i);
        if (o.en) seen.push_back(int'(o.addr));
    end

    // max-pool consumer on instance 0: registers flags, takes data one cycle later
    bit    pe = 0, pf = 0, pl = 0;
    int    wi = 0;
    word_t acc = '0;
    always @(negedge clk) begin
        obs_t o;
        if (rst) begin
            pe = 0; wi = 0;
        end else if (chk_en) begin
            o = get_obs(0);
            if (pe) begin
                acc = pf ? o.data : pack_max(acc, o.data);
                if (pl) begin
                    chk("win_max", 64'(acc), 64'(win_max(0, wi % 4)));
                    wi++;
                end
            end
            pe = o.en; pf = o.first; pl = o.last;
        end
    end

    task automatic check_seq(string nm, int lit[$]);
        chk({nm, " count"}, 64'(seen.size()), 64'(lit.size()));
        for (int k = 0; k < lit.size(); k++)
            chk($sformatf("%s addr%0d", nm, k), (k < seen.size()) ? 64'(seen[k]) : 64'hFFFF, 64'(lit[k]));
    endtask

    task automatic run_pass(int i, int exp_done, bit repulse, bit tail);
        int cnt = 0;
        bit got = 0;
        act_i = i;
        seen.delete();
        @(negedge clk);
        set_start(i, 1);
        while (!got && cnt < 300) begin
            @(negedge clk);
            cnt++;
            set_start(i, repulse && (cnt == 3 || cnt == exp_done));
            if (get_obs(i).done) got = 1;
        end
        chk($sformatf("i%0d done_cycle", i), got ? 64'(cnt) : 64'hFFFF, 64'(exp_done));
        if (tail) begin
            @(negedge clk);
            set_start(i, 0);
        end
    endtask

    initial begin
        word_t m;
        rst = 0;
        if0.start = 0; if1.start = 0; if2.start = 0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) cmp_obs($sformatf("rst i%0d", i), get_obs(i), '0);
        chk_en = 1;

        // the signed max model itself
        m = '0; m[0] = 8'hFB;
        m = pack_max(m, word_t'(8'hFE)); m = pack_max(m, word_t'(8'hF7)); m = pack_max(m, word_t'(8'hF9));
        chk("model max{-5,-2,-9,-7}", 64'(m[0]), 64'h00FE);

        @(negedge clk); #2 rst = 0;

        run_pass(0, 17, 0, 1); check_seq("t1", lit1);
        run_pass(1, 17, 0, 1); check_seq("t2", lit2);
        run_pass(2, 10, 0, 1); check_seq("t3", lit3);
        run_pass(0, 17, 1, 1); check_seq("t4", lit1);

        // abort at cycle 6
        act_i = 0;
        @(negedge clk); set_start(0, 1);
        for (int c = 1; c <= 6; c++) begin @(negedge clk); set_start(0, 0); end
        #2 rst = 1;
        #1 cmp_obs("async_rst", get_obs(0), '0);
        repeat (2) @(negedge clk);
        #2 rst = 0;
        run_pass(0, 17, 0, 1); check_seq("t5", lit1);

        // back-to-back passes
        run_pass(0, 17, 0, 0); check_seq("t6a", lit1);
        run_pass(0, 17, 0, 1); check_seq("t6b", lit1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
